// File: rtl/mash_pkg.sv
// ---------------------------------------------------------------------------
// mash_pkg
// Shared constants for the axis_mash_n MASH delta-sigma modulator:
//   - MASH_MAX_ORDER_LIMIT : largest supported cascade depth
//   - MASH_BINOM           : signed noise-cancellation coefficients
//                            (-1)^j * C(k-1, j), indexed [k-1][j]
//   - mash_min_dac_bw()    : smallest signed output width for an order
//   - MASH_LFSR_SEED/TAPS  : dither LFSR constants (MASH_DITHER_EN builds)
// ---------------------------------------------------------------------------
package mash_pkg;

    localparam int MASH_MAX_ORDER_LIMIT = 4;

    // Row k-1 holds the coefficients applied to c_k[n], c_k[n-1], ...
    localparam int MASH_BINOM [MASH_MAX_ORDER_LIMIT][MASH_MAX_ORDER_LIMIT] = '{
        '{1,  0, 0,  0},
        '{1, -1, 0,  0},
        '{1, -2, 1,  0},
        '{1, -3, 3, -1}
    };

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10
    localparam logic [15:0] MASH_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] MASH_LFSR_TAPS = 16'hB400;

    // Order K spans [-(2^(K-1)-1), 2^(K-1)], which needs K+1 signed bits.
    function automatic int mash_min_dac_bw(input int order);
        return order + 1;
    endfunction

endpackage

// File: rtl/mash_efm_stage.sv
// ---------------------------------------------------------------------------
// mash_efm_stage
// One first-order error-feedback stage of the MASH cascade: accumulator,
// carry output and a shift register of past carries.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : advance the stage (one accepted sample)
//   i_clr          : stage disabled; force in/acc/carry to 0, clear history
//   i_cin          : carry-in to the adder (dither bit on stage 1)
//   i_in           : stage input
//   o_acc_next     : post-update accumulator value (feeds the next stage)
//   o_carry        : carry of the current sample
//   o_hist         : past carries, bit 0 = c[n-1], bit 1 = c[n-2], ...
// ---------------------------------------------------------------------------
module mash_efm_stage #(
    parameter int WIDTH  = 16,
    parameter int HIST_D = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic              i_cin,
    input  logic [WIDTH-1:0]  i_in,
    output logic [WIDTH-1:0]  o_acc_next,
    output logic              o_carry,
    output logic [HIST_D-1:0] o_hist
);

    logic [WIDTH-1:0]  r_acc;
    logic [HIST_D-1:0] r_hist;
    logic [WIDTH:0]    w_sum;

    // The top bit of the WIDTH+1 sum is the overflow, which is the carry.
    assign w_sum      = {1'b0, r_acc} + {1'b0, i_in} + {{WIDTH{1'b0}}, i_cin};
    assign o_acc_next = i_clr ? '0 : w_sum[WIDTH-1:0];
    assign o_carry    = i_clr ? 1'b0 : w_sum[WIDTH];
    assign o_hist     = r_hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc  <= '0;
            r_hist <= '0;
        end else if (i_en) begin
            r_acc  <= o_acc_next;
            r_hist <= i_clr ? '0 : ((r_hist << 1) | HIST_D'(o_carry));
        end
    end

endmodule

// File: rtl/axis_mash_n.sv
// ---------------------------------------------------------------------------
// axis_mash_n
// Multi-stage MASH 1-1-..-1 delta-sigma modulator with AXI-Stream handshake.
// Unsigned samples in, signed multi-level code out.
// Optional feature macro: MASH_DITHER_EN (16-bit LFSR carry-in dither on
// stage 1). Without it the carry-in is 0.
// Ports:
//   aclk, arst_n          : clock, asynchronous active-low reset
//   order_sel             : runtime order, 0 or > MAX_ORDER means MAX_ORDER
//   s_axis_data_*         : input stream (unsigned WIDTH-bit samples)
//   m_axis_data_*         : output stream (signed DAC_BW-bit code)
//   dsm_data              : stage-1 carry of the sample on m_axis_data_tdata
// ---------------------------------------------------------------------------
module axis_mash_n
    import mash_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_ORDER = 3,
    parameter int DAC_BW    = 4
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic [2:0]        order_sel,
    input  logic [WIDTH-1:0]  s_axis_data_tdata,
    input  logic              s_axis_data_tvalid,
    output logic              s_axis_data_tready,
    output logic [DAC_BW-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready,
    output logic              dsm_data
);

    localparam int HIST_D = (MAX_ORDER > 1) ? MAX_ORDER - 1 : 1;

    generate
        if (MAX_ORDER < 1 || MAX_ORDER > MASH_MAX_ORDER_LIMIT) begin : g_bad_order
            $error("axis_mash_n: MAX_ORDER must be 1..4");
        end
        if (DAC_BW < mash_min_dac_bw(MAX_ORDER)) begin : g_bad_bw
            $error("axis_mash_n: DAC_BW too small for MAX_ORDER");
        end
    endgenerate

    logic                     w_accept;
    logic                     w_cin;
    logic [2:0]               w_order;
    logic [MAX_ORDER-1:0]     w_active;
    logic [MAX_ORDER-1:0]     w_carry;
    logic [WIDTH-1:0]         w_in       [MAX_ORDER];
    logic [WIDTH-1:0]         w_acc_next [MAX_ORDER];
    logic [HIST_D-1:0]        w_hist     [MAX_ORDER];
    logic signed [DAC_BW-1:0] w_y;

    logic signed [DAC_BW-1:0] r_tdata;
    logic                     r_tvalid;
    logic                     r_dsm;

    // Single output register: a new sample may enter whenever the register
    // is empty or is being drained on this same edge.
    assign s_axis_data_tready = !r_tvalid || m_axis_data_tready;
    assign w_accept           = s_axis_data_tvalid && s_axis_data_tready;

    assign w_order = (order_sel == 3'd0 || order_sel > 3'(MAX_ORDER))
                   ? 3'(MAX_ORDER) : order_sel;

    always_comb begin
        w_active = '0;
        for (int k = 0; k < MAX_ORDER; k++) begin
            w_active[k] = (k < int'(w_order));
        end
    end

`ifdef MASH_DITHER_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_lfsr <= MASH_LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & MASH_LFSR_TAPS)};
        end
    end

    assign w_cin = r_lfsr[0];
`else
    assign w_cin = 1'b0;
`endif

    // Each stage integrates the freshly updated accumulator of the stage
    // before it, so the whole cascade settles within one cycle. Disabled
    // stages are cleared on every accept, which also wipes their history on
    // the accept where the order drops.
    generate
        for (genvar gi = 0; gi < MAX_ORDER; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_in[gi] = s_axis_data_tdata;
            end else begin : g_rest
                assign w_in[gi] = w_acc_next[gi-1];
            end

            mash_efm_stage #(
                .WIDTH  (WIDTH),
                .HIST_D (HIST_D)
            ) u_stage (
                .i_clk      (aclk),
                .i_rst_n    (arst_n),
                .i_en       (w_accept),
                .i_clr      (!w_active[gi]),
                .i_cin      ((gi == 0) ? w_cin : 1'b0),
                .i_in       (w_in[gi]),
                .o_acc_next (w_acc_next[gi]),
                .o_carry    (w_carry[gi]),
                .o_hist     (w_hist[gi])
            );
        end
    endgenerate

    // Noise cancellation: y = sum_k sum_j (-1)^j C(k-1,j) c_k[n-j].
    // Gating by w_active matters on the accept where the order drops: the
    // dropped stage's history still holds old carries at that moment.
    always_comb begin
        w_y = '0;
        for (int k = 0; k < MAX_ORDER; k++) begin
            if (w_active[k] && w_carry[k]) begin
                w_y = w_y + DAC_BW'(MASH_BINOM[k][0]);
            end
            for (int j = 1; j < MAX_ORDER; j++) begin
                if (w_active[k] && w_hist[k][j-1]) begin
                    w_y = w_y + DAC_BW'(MASH_BINOM[k][j]);
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_dsm    <= 1'b0;
        end else if (w_accept) begin
            r_tdata  <= w_y;
            r_tvalid <= 1'b1;
            r_dsm    <= w_carry[0];
        end else if (m_axis_data_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_data_tdata  = r_tdata;
    assign m_axis_data_tvalid = r_tvalid;
    assign dsm_data           = r_dsm;

endmodule

// File: tb/tb_axis_mash_n.sv
// ---------------------------------------------------------------------------
// tb_axis_mash_n
// Directed bench for axis_mash_n (WIDTH=16, MAX_ORDER=3, DAC_BW=4, default
// build without dither). Short hand-computed tables for the half-scale
// order-1/2 cases, and a small behavioural MASH model for x=12345 runs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_mash_n;

    localparam int WIDTH     = 16;
    localparam int MAX_ORDER = 3;
    localparam int DAC_BW    = 4;

    logic              aclk      = 1'b0;
    logic              arst_n    = 1'b0;
    logic [2:0]        order_sel = 3'd3;
    logic [WIDTH-1:0]  s_tdata   = '0;
    logic              s_tvalid  = 1'b0;
    logic              s_tready;
    logic [DAC_BW-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready  = 1'b1;
    logic              dsm_data;

    axis_mash_n #(
        .WIDTH     (WIDTH),
        .MAX_ORDER (MAX_ORDER),
        .DAC_BW    (DAC_BW)
    ) u_dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .order_sel          (order_sel),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .m_axis_data_tready (m_tready),
        .dsm_data           (dsm_data)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sy();
        return int'($signed(m_tdata));
    endfunction

    // Reference MASH model: m_h1/m_h2 hold c_k[n-1] / c_k[n-2].
    int m_acc [4];
    int m_h1  [4];
    int m_h2  [4];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_acc[k] = 0;
            m_h1[k]  = 0;
            m_h2[k]  = 0;
        end
    endtask

    task automatic model_step(input int x, input int k_ord, output int y, output int c1);
        int in_v;
        int s;
        int c [4];
        in_v = x;
        c[0] = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k <= k_ord) begin
                s        = m_acc[k] + in_v;
                c[k]     = (s >= 65536) ? 1 : 0;
                m_acc[k] = s % 65536;
                in_v     = m_acc[k];
            end else begin
                c[k]     = 0;
                m_acc[k] = 0;
                m_h1[k]  = 0;
                m_h2[k]  = 0;
            end
        end
        y = c[1];
        if (k_ord >= 2) y = y + c[2] - m_h1[2];
        if (k_ord >= 3) y = y + c[3] - 2 * m_h1[3] + m_h2[3];
        for (int k = 1; k <= k_ord; k++) begin
            m_h2[k] = m_h1[k];
            m_h1[k] = c[k];
        end
        c1 = c[1];
    endtask

    task automatic do_reset();
        arst_n   = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        arst_n = 1'b1;
        model_reset();
    endtask

    // Present one sample; returns 1 ns after the edge that accepted it.
    task automatic send(input int x, input int ord);
        s_tdata   = WIDTH'(x);
        order_sel = 3'(ord);
        s_tvalid  = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    // Send one x=12345 sample and compare against the model.
    task automatic send_model(input string tag, input int ord);
        int y;
        int c1;
        send(12345, ord);
        model_step(12345, ord, y, c1);
        chk({tag, "_y"}, sy(), y);
        chk({tag, "_dsm"}, int'(dsm_data), c1);
        chk({tag, "_tvalid"}, int'(m_tvalid), 1);
    endtask

    initial begin
        int o1_pat [2];
        int o2_pat [4];
        int rec    [37];
        int sum;
        int lo;
        int hi;
        int held;
        int yd;

        o1_pat = '{0, 1};
        o2_pat = '{0, 1, 1, 0};

        // Reset state
        #3;
        chk("rst_tvalid", int'(m_tvalid), 0);
        chk("rst_tdata", sy(), 0);
        chk("rst_dsm", int'(dsm_data), 0);
        do_reset();
        chk("rst_s_tready", int'(s_tready), 1);
        $display("[TB] reset state checked");

        // Zero input, order 3
        for (int i = 0; i < 1000; i++) begin
            send(0, 3);
            chk("zero_y", sy(), 0);
            chk("zero_dsm", int'(dsm_data), 0);
        end
        chk("zero_tvalid", int'(m_tvalid), 1);
        $display("[TB] zero input: 1000 samples");

        // Half scale, order 1
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(32768, 1);
            chk("o1_y", sy(), o1_pat[i % 2]);
            chk("o1_dsm", int'(dsm_data), o1_pat[i % 2]);
        end
        $display("[TB] half scale order 1: 16 samples");

        // Half scale, order 2
        do_reset();
        sum = 0;
        lo  = 100;
        hi  = -100;
        for (int i = 0; i < 1024; i++) begin
            send(32768, 2);
            yd = sy();
            chk("o2_y", yd, o2_pat[i % 4]);
            sum = sum + yd;
            if (yd < lo) lo = yd;
            if (yd > hi) hi = yd;
        end
        chk("o2_sum", sum, 512);
        chk("o2_min_in_range", int'(lo >= -1), 1);
        chk("o2_max_in_range", int'(hi <= 2), 1);
        $display("[TB] half scale order 2: 1024 samples, sum %0d", sum);

        // Backpressure, order 3
        do_reset();
        for (int i = 0; i < 20; i++) send_model("bp_pre", 3);
        m_tready = 1'b0;
        #1;
        held = sy();
        chk("bp_s_tready_low", int'(s_tready), 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            chk("bp_hold_y", sy(), held);
            chk("bp_hold_tvalid", int'(m_tvalid), 1);
            chk("bp_hold_s_tready", int'(s_tready), 0);
        end
        m_tready = 1'b1;
        #1;
        chk("bp_s_tready_back", int'(s_tready), 1);
        for (int i = 0; i < 20; i++) send_model("bp_post", 3);
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        chk("idle_tvalid", int'(m_tvalid), 0);
        chk("idle_s_tready", int'(s_tready), 1);
        for (int i = 0; i < 10; i++) send_model("idle_post", 3);
        $display("[TB] backpressure: 5 held cycles, 1 idle cycle");

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 37; i++) begin
            send_model("mrst_pre", 3);
            rec[i] = sy();
        end
        for (int i = 0; i < 5; i++) send_model("mrst_more", 3);
        arst_n = 1'b0;
        #1;
        chk("mrst_tvalid", int'(m_tvalid), 0);
        chk("mrst_tdata", sy(), 0);
        chk("mrst_dsm", int'(dsm_data), 0);
        s_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        arst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 37; i++) begin
            send(12345, 3);
            chk("mrst_replay_y", sy(), rec[i]);
        end
        $display("[TB] reset mid-stream: 37 samples replayed");

        // Order change 3 -> 1 -> 3
        do_reset();
        for (int i = 0; i < 100; i++) send_model("oc_o3", 3);
        for (int i = 0; i < 60; i++) begin
            send_model("oc_o1", 1);
            yd = sy();
            chk("oc_o1_range", int'(yd == 0 || yd == 1), 1);
        end
        for (int i = 0; i < 30; i++) send_model("oc_back_o3", 3);
        $display("[TB] order change: 100 x3, 60 x1, 30 x3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
